sync_fifo_wr_arbiter: RTL and testbench

- Shares the write port of one sync_fifo_with_clear instance between NUM_REQ independent producers.
- Uses round-robin arbitration with a bounded burst per grant, so no producer can starve the others.
- Backpressures producers from the FIFO full flag.
- Sequences FIFO clear requests so that a clear never coincides with a write; sits directly in front of the FIFO write interface.

---
 rtl/sync_fifo_arb_pkg.sv | 49 ++++
 rtl/sync_fifo_wr_arbiter_core.sv | 35 +++
 rtl/sync_fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_arb_pkg.sv
// Purpose: shared types and the rotating-priority search used by the FIFO write arbiter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   arb_state_e  - arbiter FSM states (IDLE, GRANT, FLUSH)
//   rr_next_idx  - first valid index after last_idx, searching upward with wrap
package sync_fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

   // Upper bound on requesters the search function can handle; the valid
   // vector is zero-extended to this width by callers.
   localparam int ARB_MAX_REQ = 32;
   localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

   // Returns the first index k with valid[k] set, scanning
   // last_idx+1, last_idx+2, ... modulo num_req. Returns last_idx when
   // nothing is valid, so callers must qualify the result with |valid.
   // The loop has a constant trip count so it unrolls into a priority chain;
   // the wrap is a conditional subtract because last_idx + i < 2*num_req.
   function automatic int rr_next_idx(
      input logic [ARB_MAX_REQ-1:0] valid,
      input int                     last_idx,
      input int                     num_req
   );
      int   sel;
      int   cand;
      logic found;
      sel   = last_idx;
      found = 1'b0;
      for (int i = 1; i <= ARB_MAX_REQ; i++) begin
         cand = last_idx + i;
         if (cand >= num_req) begin
            cand = cand - num_req;
         end
         if (!found && (i <= num_req) && valid[cand[ARB_IDX_W-1:0]]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_core.sv
// Purpose: combinational rotating-priority picker (round-robin after last_idx).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
//
// Ports:
//   i_valid        - per-requester valid vector
//   i_last_idx     - index granted most recently; search starts one above it
//   o_onehot_grant - one-hot pick, all zero when nothing is valid
//   o_grant_idx    - binary index of the pick (meaningful only with o_any_valid)
//   o_any_valid    - at least one requester is valid
module rr_arbiter_core
   import sync_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_last_idx,
   output logic [NUM_REQ-1:0] o_onehot_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any_valid
);

   int sel_idx;

   always_comb begin
      sel_idx     = rr_next_idx(ARB_MAX_REQ'(i_valid), int'(i_last_idx), NUM_REQ);
      o_any_valid = |i_valid;
      o_grant_idx = IDX_W'(sel_idx);
      for (int k = 0; k < NUM_REQ; k++) begin
         o_onehot_grant[k] = o_any_valid && (sel_idx == k);
      end
   end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Purpose: shares one FIFO write port between NUM_REQ producers, round-robin with bounded bursts, and sequences FIFO clears.
// Latency: valid -> first ready is 1 cycle (arbitration in IDLE); every re-arbitration costs one IDLE bubble.
// Backpressure: ready to the granted producer drops while the FIFO is full or a flush is pending; grant holds while full.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   i_req_valid      - per-requester valid
//   i_req_data       - per-requester data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready      - per-requester ready, at most one bit high
//   o_grant          - registered one-hot grant, zero when no grant
//   i_flush_req      - level request to clear the FIFO, held until o_flush_ack
//   o_flush_ack      - one-cycle pulse in the cycle the clear is issued
//   o_fifo_wr_en     - FIFO write enable
//   o_fifo_wr_data   - FIFO write data (granted slice while in GRANT, else 0)
//   i_fifo_full      - FIFO full flag
//   o_fifo_clr       - FIFO synchronous clear
//   o_busy           - FSM is not in IDLE
module sync_fifo_wr_arbiter
   import sync_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic [NUM_REQ-1:0]            o_grant,
   input  logic                          i_flush_req,
   output logic                          o_flush_ack,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
   input  logic                          i_fifo_full,
   output logic                          o_fifo_clr,
   output logic                          o_busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e         state_q,     state_d;
   logic [NUM_REQ-1:0] grant_q,     grant_d;
   logic [IDX_W-1:0]   last_idx_q,  last_idx_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [NUM_REQ-1:0] arb_onehot;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               sel_valid;
   logic               xfer;

   rr_arbiter_core #(
      .NUM_REQ (NUM_REQ)
   ) u_core (
      .i_valid        (i_req_valid),
      .i_last_idx     (last_idx_q),
      .o_onehot_grant (arb_onehot),
      .o_grant_idx    (arb_idx),
      .o_any_valid    (arb_any)
   );

   // While in GRANT, last_idx_q is the granted index, so it doubles as the
   // datapath mux select and no separate binary grant register is needed.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_idx_d     = last_idx_q;
      burst_cnt_d    = burst_cnt_q;
      o_req_ready    = '0;
      o_fifo_wr_en   = 1'b0;
      o_fifo_wr_data = '0;
      sel_valid      = 1'b0;
      xfer           = 1'b0;

      case (state_q)
         IDLE: begin
            // A pending flush wins over arbitration so the clear never
            // lands between writes of a burst.
            if (i_flush_req) begin
               state_d = FLUSH;
            end else if (arb_any) begin
               state_d     = GRANT;
               grant_d     = arb_onehot;
               last_idx_d  = arb_idx;
               burst_cnt_d = '0;
            end
         end

         GRANT: begin
            sel_valid      = i_req_valid[last_idx_q];
            // Flush suppresses ready so no write can coincide with the clear
            // that follows two cycles later.
            o_req_ready    = (i_fifo_full || i_flush_req) ? '0 : grant_q;
            xfer           = sel_valid && !i_fifo_full && !i_flush_req;
            o_fifo_wr_en   = xfer;
            o_fifo_wr_data = i_req_data[last_idx_q*DATA_WIDTH +: DATA_WIDTH];
            burst_cnt_d    = burst_cnt_q + CNT_W'(xfer);
            // Full with valid held is a stall: grant and count both hold.
            if ((xfer && (burst_cnt_d == CNT_W'(MAX_BURST))) || !sel_valid || i_flush_req) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end

         FLUSH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_idx_q  <= IDX_W'(NUM_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_idx_q  <= last_idx_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Decoded straight from the state register, so these are glitch-free
   // and drop with the asynchronous reset.
   assign o_grant     = grant_q;
   assign o_fifo_clr  = (state_q == FLUSH);
   assign o_flush_ack = (state_q == FLUSH);
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
module tb_sync_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    i_req_valid;
   logic [NR*DW-1:0] i_req_data;
   logic [NR-1:0]    o_req_ready;
   logic [NR-1:0]    o_grant;
   logic             i_flush_req;
   logic             o_flush_ack;
   logic             o_fifo_wr_en;
   logic [DW-1:0]    o_fifo_wr_data;
   logic             i_fifo_full;
   logic             o_fifo_clr;
   logic             o_busy;

   sync_fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req_valid    (i_req_valid),
      .i_req_data     (i_req_data),
      .o_req_ready    (o_req_ready),
      .o_grant        (o_grant),
      .i_flush_req    (i_flush_req),
      .o_flush_ack    (o_flush_ack),
      .o_fifo_wr_en   (o_fifo_wr_en),
      .o_fifo_wr_data (o_fifo_wr_data),
      .i_fifo_full    (i_fifo_full),
      .o_fifo_clr     (o_fifo_clr),
      .o_busy         (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // producer sources, expected-write scoreboard and monitor logs
   logic [DW-1:0] src_mem [NR][16];
   int            src_wr  [NR];
   int            src_rd  [NR];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_d;
   int            glog_idx [$];
   int            glog_cyc [$];
   int            glog_wr  [$];
   logic [NR-1:0] prev_grant = '0;
   int            wcnt = 0;
   int            cyc = 0;
   int            clr_cnt = 0;
   int            fifo_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int oh_idx(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int k = NR - 1; k >= 0; k--) if (v[k]) r = k;
      return r;
   endfunction

   function automatic logic srcs_empty();
      logic e;
      e = 1'b1;
      for (int k = 0; k < NR; k++) if (src_rd[k] != src_wr[k]) e = 1'b0;
      return e;
   endfunction

   task automatic load(input int k, input logic [DW-1:0] d);
      if (src_rd[k] == src_wr[k]) begin
         src_rd[k] = 0;
         src_wr[k] = 0;
      end
      src_mem[k][src_wr[k]] = d;
      src_wr[k]++;
   endtask

   task automatic drive_srcs();
      for (int k = 0; k < NR; k++) begin
         if (src_rd[k] < src_wr[k]) begin
            i_req_valid[k]          = 1'b1;
            i_req_data[k*DW +: DW]  = src_mem[k][src_rd[k]];
         end else begin
            i_req_valid[k]          = 1'b0;
            i_req_data[k*DW +: DW]  = '0;
         end
      end
   endtask

   task automatic clear_srcs();
      for (int k = 0; k < NR; k++) begin
         src_rd[k] = 0;
         src_wr[k] = 0;
      end
   endtask

   // One clock: handshakes are taken from the settled pre-edge values,
   // then producers advance and present their next word.
   task automatic step();
      logic [NR-1:0] acc;
      #1;
      acc = i_req_valid & o_req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (acc[k]) src_rd[k]++;
      drive_srcs();
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(srcs_empty() && !o_busy) && n < 300);
      chk({tag, "_timeout"}, 32'(n < 300), 1);
      step();
      step();
   endtask

   task automatic clear_logs();
      glog_idx.delete();
      glog_cyc.delete();
      glog_wr.delete();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      i_flush_req = 1'b0;
      i_fifo_full = 1'b0;
      clear_srcs();
      drive_srcs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      clear_logs();
   endtask

   // monitor: scoreboard every FIFO write, check invariants, log grants
   always @(negedge clk) begin
      cyc++;
      if (o_grant != '0 && prev_grant == '0) begin
         glog_idx.push_back(oh_idx(o_grant));
         glog_cyc.push_back(cyc);
         wcnt = 0;
      end
      if (o_fifo_wr_en) begin
         chk("sb_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_d = exp_q.pop_front();
            chk("wr_data", 32'(o_fifo_wr_data), 32'(exp_d));
         end
         chk("wr_while_full", 32'(i_fifo_full), 0);
         chk("wr_with_clr", 32'(o_fifo_clr), 0);
         wcnt++;
         fifo_cnt++;
      end
      if (o_fifo_clr) begin
         clr_cnt++;
         fifo_cnt = 0;
      end
      if (o_grant == '0 && prev_grant != '0) glog_wr.push_back(wcnt);
      prev_grant = o_grant;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int clr0;
      int eg [8];
      rst_n       = 1'b0;
      i_flush_req = 1'b0;
      i_fifo_full = 1'b0;
      i_req_valid = '0;
      i_req_data  = '0;
      clear_srcs();
      #3;
      // asynchronous reset state, before any clock edge
      chk("rst_grant", 32'(o_grant), 0);
      chk("rst_ready", 32'(o_req_ready), 0);
      chk("rst_wr_en", 32'(o_fifo_wr_en), 0);
      chk("rst_clr", 32'(o_fifo_clr), 0);
      chk("rst_ack", 32'(o_flush_ack), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_wr_data", 32'(o_fifo_wr_data), 0);
      do_reset();

      // ---- 1: single requester 2, six words, burst 4 then regrant ----
      for (int i = 0; i < 6; i++) begin
         load(2, 8'(8'hA1 + i));
         exp_q.push_back(8'(8'hA1 + i));
      end
      drive_srcs();
      #1;
      chk("t1_idle_grant", 32'(o_grant), 0);
      chk("t1_idle_ready", 32'(o_req_ready), 0);
      step();
      chk("t1_grant", 32'(o_grant), 32'b0100);
      chk("t1_ready", 32'(o_req_ready), 32'b0100);
      chk("t1_wr_data", 32'(o_fifo_wr_data), 32'hA1);
      wait_idle("t1");
      chk("t1_ngrants", glog_idx.size(), 2);
      chk("t1_g0", glog_idx[0], 2);
      chk("t1_g1", glog_idx[1], 2);
      chk("t1_w0", glog_wr[0], 4);
      chk("t1_w1", glog_wr[1], 2);
      chk("t1_gap", glog_cyc[1] - glog_cyc[0], 5);
      chk("t1_sb_empty", exp_q.size(), 0);

      // ---- 2: all four continuously valid, two full rounds ----
      do_reset();
      for (int k = 0; k < NR; k++)
         for (int i = 0; i < 8; i++) load(k, 8'(k*16 + i));
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NR; k++)
            for (int j = 0; j < MB; j++) exp_q.push_back(8'(k*16 + r*4 + j));
      eg = '{0, 1, 2, 3, 0, 1, 2, 3};
      drive_srcs();
      wait_idle("t2");
      chk("t2_ngrants", glog_idx.size(), 8);
      chk("t2_nwr", glog_wr.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t2_order", glog_idx[i], eg[i]);
         chk("t2_burst", glog_wr[i], MB);
         if (i > 0) chk("t2_gap", glog_cyc[i] - glog_cyc[i-1], 5);
      end
      chk("t2_sb_empty", exp_q.size(), 0);
      clear_logs();

      // ---- 3: FIFO full for 5 cycles after 2 writes ----
      for (int i = 0; i < 4; i++) begin
         load(0, 8'(8'hB0 + i));
         exp_q.push_back(8'(8'hB0 + i));
      end
      drive_srcs();
      step();
      chk("t3_grant", 32'(o_grant), 32'b0001);
      step();
      chk("t3_wr2", 32'(o_fifo_wr_en), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         i_fifo_full = 1'b1;
         #1;
         chk("t3_full_ready", 32'(o_req_ready), 0);
         chk("t3_full_wr_en", 32'(o_fifo_wr_en), 0);
         chk("t3_full_grant", 32'(o_grant), 32'b0001);
      end
      step();
      i_fifo_full = 1'b0;
      #1;
      chk("t3_resume_wr", 32'(o_fifo_wr_en), 1);
      chk("t3_resume_data", 32'(o_fifo_wr_data), 32'hB2);
      wait_idle("t3");
      chk("t3_ngrants", glog_idx.size(), 1);
      chk("t3_w0", glog_wr[0], 4);
      chk("t3_sb_empty", exp_q.size(), 0);
      clear_logs();

      // ---- 4: flush during GRANT after one write ----
      clr0 = clr_cnt;
      for (int i = 0; i < 3; i++) begin
         load(1, 8'(8'hC0 + i));
         exp_q.push_back(8'(8'hC0 + i));
      end
      drive_srcs();
      step();
      chk("t4_grant", 32'(o_grant), 32'b0010);
      chk("t4_wr0", 32'(o_fifo_wr_en), 1);
      step();
      i_flush_req = 1'b1;
      #1;
      chk("t4_flush_ready", 32'(o_req_ready), 0);
      chk("t4_flush_wr_en", 32'(o_fifo_wr_en), 0);
      chk("t4_flush_clr_early", 32'(o_fifo_clr), 0);
      step();
      chk("t4_idle_grant", 32'(o_grant), 0);
      chk("t4_idle_busy", 32'(o_busy), 0);
      chk("t4_idle_clr", 32'(o_fifo_clr), 0);
      step();
      chk("t4_clr", 32'(o_fifo_clr), 1);
      chk("t4_ack", 32'(o_flush_ack), 1);
      chk("t4_clr_wr_en", 32'(o_fifo_wr_en), 0);
      chk("t4_clr_busy", 32'(o_busy), 1);
      i_flush_req = 1'b0;
      step();
      chk("t4_clr_pulse", 32'(o_fifo_clr), 0);
      chk("t4_ack_pulse", 32'(o_flush_ack), 0);
      chk("t4_fifo_empty", fifo_cnt, 0);
      wait_idle("t4");
      chk("t4_nclr", clr_cnt - clr0, 1);
      chk("t4_ngrants", glog_idx.size(), 2);
      chk("t4_w0", glog_wr[0], 1);
      chk("t4_g1", glog_idx[1], 1);
      chk("t4_sb_empty", exp_q.size(), 0);
      clear_logs();

      // ---- 5: flush and requests arrive together in IDLE ----
      load(2, 8'hD0);
      load(3, 8'hD1);
      exp_q.push_back(8'hD0);
      exp_q.push_back(8'hD1);
      i_flush_req = 1'b1;
      drive_srcs();
      #1;
      chk("t5_idle_grant", 32'(o_grant), 0);
      step();
      chk("t5_flush_clr", 32'(o_fifo_clr), 1);
      chk("t5_flush_grant", 32'(o_grant), 0);
      chk("t5_flush_ready", 32'(o_req_ready), 0);
      i_flush_req = 1'b0;
      step();
      chk("t5_idle_after", 32'(o_busy), 0);
      chk("t5_idle_clr", 32'(o_fifo_clr), 0);
      step();
      chk("t5_grant", 32'(o_grant), 32'b0100);
      chk("t5_data", 32'(o_fifo_wr_data), 32'hD0);
      wait_idle("t5");
      chk("t5_ngrants", glog_idx.size(), 2);
      chk("t5_g1", glog_idx[1], 3);
      chk("t5_sb_empty", exp_q.size(), 0);
      clear_logs();

      // ---- 6: asynchronous reset mid-burst ----
      for (int i = 0; i < 4; i++) load(0, 8'(8'hE0 + i));
      exp_q.push_back(8'hE0);
      exp_q.push_back(8'hE1);
      drive_srcs();
      step();
      chk("t6_grant", 32'(o_grant), 32'b0001);
      step();
      step();
      chk("t6_pre_rst_wr", 32'(o_fifo_wr_en), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(o_grant), 0);
      chk("t6_rst_ready", 32'(o_req_ready), 0);
      chk("t6_rst_wr_en", 32'(o_fifo_wr_en), 0);
      chk("t6_rst_wr_data", 32'(o_fifo_wr_data), 0);
      chk("t6_rst_busy", 32'(o_busy), 0);
      clear_srcs();
      drive_srcs();
      step();
      step();
      chk("t6_sb_empty_rst", exp_q.size(), 0);
      clear_logs();
      load(1, 8'hF0);
      load(1, 8'hF1);
      load(3, 8'hF2);
      load(3, 8'hF3);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hF0 + i));
      drive_srcs();
      #1;
      rst_n = 1'b1;
      step();
      chk("t6_first_grant", 32'(o_grant), 32'b0010);
      wait_idle("t6");
      chk("t6_ngrants", glog_idx.size(), 2);
      chk("t6_g1", glog_idx[1], 3);
      chk("t6_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
